// File: rtl/calc_pkg.sv
// Shared display constants and types for the calculator's 7-segment output path.
package calc_pkg;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned MAX_OPERAND = 9999;

  typedef logic [3:0] bcd_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } conv_state_e;

  // Non-decimal nibbles cannot come out of the converter; show them blank regardless
  function automatic logic [6:0] seg_of_digit(input bcd_t d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = SEG_DIGIT[0];
      4'd1:    pat = SEG_DIGIT[1];
      4'd2:    pat = SEG_DIGIT[2];
      4'd3:    pat = SEG_DIGIT[3];
      4'd4:    pat = SEG_DIGIT[4];
      4'd5:    pat = SEG_DIGIT[5];
      4'd6:    pat = SEG_DIGIT[6];
      4'd7:    pat = SEG_DIGIT[7];
      4'd8:    pat = SEG_DIGIT[8];
      4'd9:    pat = SEG_DIGIT[9];
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: captures a new operand whenever it differs from the
// last one converted, shifts one bit per clock, and publishes four BCD digits plus an
// out-of-range flag when done. Inputs changing mid-conversion are picked up afterwards.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic [15:0]      bcd,
  output logic             ovf
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned SrW  = BcdW + BIN_W;
  localparam int unsigned CntW = $clog2(BIN_W);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] cap_q, cap_d;
  logic [SrW-1:0]   sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [BcdW-1:0]  bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  logic [SrW-1:0]   sr_adj;
  logic [SrW-1:0]   sr_shift;

  // Add-3 correction on every BCD nibble, then the one-bit shift
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[SrW-2:0], 1'b0};
  end

  // Next-state: capture on a changed operand, shift BIN_W times, then publish
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (bin != cap_q) begin
          cap_d   = bin;
          sr_d    = {{BcdW{1'b0}}, bin};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(BIN_W - 1)) begin
          bcd_d   = sr_shift[SrW-1 -: BcdW];
          ovf_d   = (32'(cap_q) > MAX_OPERAND);
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cap_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed common-anode display driver: converts the operand to BCD and
// scans one digit per refresh slot, with optional leading-zero blanking and a dash
// pattern for out-of-range values.
module seg7_display_driver
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BIN_W       = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  input  logic             blank_lz,
  output logic             busy,
  output logic             overflow,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [15:0]           bcd;
  logic [CntW-1:0]       refresh_q, refresh_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  wrap;
  logic [1:0]            idx_next;
  bcd_t                  digit;
  logic [NUM_DIGITS-1:0] zero_from;

  bin2bcd_seq #(
    .BIN_W(BIN_W)
  ) u_conv (
    .clk (clk),
    .rst (rst),
    .bin (value),
    .busy(busy),
    .bcd (bcd),
    .ovf (overflow)
  );

  // zero_from[i]: digits i..3 are all zero, i.e. digit i is a leading zero
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (bcd[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int i = int'(NUM_DIGITS) - 2; i >= 1; i--) begin
      zero_from[i] = zero_from[i+1] && (bcd[4*i +: 4] == 4'd0);
    end
  end

  // Refresh counter and pattern for the digit about to be lit
  always_comb begin
    wrap      = (refresh_q == CntW'(REFRESH_DIV - 1));
    refresh_d = wrap ? '0 : refresh_q + 1'b1;
    idx_next  = idx_q + 2'd1;
    digit     = bcd[{idx_next, 2'b00} +: 4];
    idx_d     = idx_q;
    an_d      = an_q;
    seg_d     = seg_q;
    if (wrap) begin
      idx_d = idx_next;
      an_d  = ~(4'b0001 << idx_next);
      if (overflow) begin
        seg_d = SEG_DASH;
      end else if (blank_lz && (idx_next != 2'd0) && zero_from[idx_next]) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = seg_of_digit(digit);
      end
    end
  end

  // Registered scan outputs so only one anode is ever active
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Self-checking bench for seg7_display_driver with a short refresh period.
module tb_seg7_display_driver;

  localparam int unsigned R = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        blank_lz;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  always #5 clk = ~clk;

  seg7_display_driver #(
    .REFRESH_DIV(R),
    .BIN_W      (14)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .blank_lz(blank_lz),
    .busy    (busy),
    .overflow(overflow),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  typedef struct packed {
    logic [13:0]     value;
    logic            blank;
    logic            ovf;
    logic [3:0][6:0] seg;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int glitches = 0;
  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] digit_pat(input int d);
    logic [6:0] tab [10];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tab[d];
  endfunction

  // Reference: decimal digit i of v by arithmetic, blanked if v has fewer than i+1 digits
  function automatic logic [6:0] model_seg(input int v, input bit bl, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v > 9999) return 7'h3F;
    if (i > 0 && bl && v < p) return 7'h7F;
    return digit_pat((v / p) % 10);
  endfunction

  function automatic vec_t mk(input int v, input bit b, input bit o, input logic [6:0] s3,
                              input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    vec_t r;
    r.value = 14'(v);
    r.blank = b;
    r.ovf   = o;
    r.seg   = {s3, s2, s1, s0};
    return r;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("%s idle", name), int'(busy), 0);
  endtask

  // Observe 5 slots and record what each anode showed
  task automatic collect(output logic [3:0][6:0] got, output logic [3:0] seen, output int bad);
    got  = '1;
    seen = '0;
    bad  = 0;
    for (int c = 0; c < int'(5 * R); c++) begin
      tick();
      case (an)
        4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
        4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
        4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
        4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
        default: bad++;
      endcase
    end
  endtask

  task automatic verify_display(input string name, input logic [3:0][6:0] exp, input logic eo);
    logic [3:0][6:0] got;
    logic [3:0]      seen;
    int              bad;
    check($sformatf("%s ovf", name), int'(overflow), int'(eo));
    collect(got, seen, bad);
    check($sformatf("%s slots seen", name), int'(seen), 'hF);
    check($sformatf("%s one-hot an", name), bad, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s seg[%0d]", name, i), int'(got[i]), int'(exp[i]));
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    value    = v.value;
    blank_lz = v.blank;
    tick();
    wait_idle(name);
    repeat (2 * R) tick();
    verify_display(name, v.seg, v.ovf);
  endtask

  function automatic vec_t model_vec(input int v, input bit bl);
    return mk(v, bl, v > 9999, model_seg(v, bl, 3), model_seg(v, bl, 2),
              model_seg(v, bl, 1), model_seg(v, bl, 0));
  endfunction

  initial begin
    vecs[0] = mk(7,     1, 0, 7'h7F, 7'h7F, 7'h7F, 7'h78);
    vecs[1] = mk(7,     0, 0, 7'h40, 7'h40, 7'h40, 7'h78);
    vecs[2] = mk(10000, 0, 1, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    vecs[3] = mk(9999,  0, 0, 7'h10, 7'h10, 7'h10, 7'h10);
    vecs[4] = mk(1234,  0, 0, 7'h79, 7'h24, 7'h30, 7'h19);
    vecs[5] = mk(0,     1, 0, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    vecs[6] = mk(100,   1, 0, 7'h7F, 7'h79, 7'h40, 7'h40);
    vecs[7] = mk(16383, 1, 1, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    vecs[8] = mk(1020,  1, 0, 7'h79, 7'h40, 7'h24, 7'h40);

    // Reset and first scan sequence
    rst      = 1'b1;
    value    = '0;
    blank_lz = 1'b0;
    repeat (3) tick();
    check("reset an", int'(an), 'hF);
    check("reset seg", int'(seg), 'h7F);
    check("reset busy", int'(busy), 0);
    check("reset ovf", int'(overflow), 0);
    check("reset dp", int'(dp), 1);
    rst = 1'b0;
    repeat (R - 1) tick();
    check("an before first slot", int'(an), 'hF);
    tick();
    check("first an", int'(an), 'b1101);
    check("first seg", int'(seg), 'h40);
    repeat (R) tick();
    check("scan an 2", int'(an), 'b1011);
    repeat (R) tick();
    check("scan an 3", int'(an), 'b0111);
    repeat (R) tick();
    check("scan an 0", int'(an), 'b1110);

    // Latency of one conversion
    value = 14'd1234;
    tick();
    check("busy after capture", int'(busy), 1);
    repeat (13) tick();
    check("busy at 14", int'(busy), 1);
    tick();
    check("busy at 15", int'(busy), 0);
    repeat (2 * R) tick();
    verify_display("lat1234", vecs[4].seg, 1'b0);

    // Table vectors
    for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Operand changes mid-conversion: old conversion finishes, then newest value converts
    apply("pre5", vecs[4]);
    value = 14'd5;
    for (int c = 1; c <= 30 + int'(2 * R); c++) begin
      tick();
      if (an == 4'b1110 && !(seg inside {7'h19, 7'h12, 7'h24})) glitches++;
      if (c == 4) value = 14'd42;
      if (c == 1)  check("mid busy c1", int'(busy), 1);
      if (c == 14) check("mid busy c14", int'(busy), 1);
      if (c == 15) check("mid busy c15", int'(busy), 0);
      if (c == 16) check("mid busy c16", int'(busy), 1);
      if (c == 29) check("mid busy c29", int'(busy), 1);
      if (c == 30) check("mid busy c30", int'(busy), 0);
    end
    check("mid glitches", glitches, 0);
    verify_display("mid42", model_vec(42, 1'b0).seg, 1'b0);

    // Reset during conversion
    value    = 14'd321;
    blank_lz = 1'b1;
    tick();
    repeat (4) tick();
    check("pre-rst busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("rst mid busy", int'(busy), 0);
    check("rst mid an", int'(an), 'hF);
    check("rst mid seg", int'(seg), 'h7F);
    check("rst mid ovf", int'(overflow), 0);
    rst = 1'b0;
    tick();
    check("reconvert busy", int'(busy), 1);
    wait_idle("rst321");
    repeat (2 * R) tick();
    verify_display("rst321", model_vec(321, 1'b1).seg, 1'b0);

    // Randomised operands against the arithmetic model
    for (int n = 0; n < 20; n++) begin
      int v;
      bit b;
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383));
      b = 1'($urandom_range(0, 1));
      apply($sformatf("rnd%0d v=%0d bl=%0d", n, v, b), model_vec(v, b));
    end
    check("dp held", int'(dp), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
